// File: rtl/wb_commit_unit_if.sv
// wb_commit_unit_if
//   Debug-trace channel between the write-back commit stage and a trace sink.
//   master : commit stage; drives the head trace record and trace_valid,
//            samples trace_ready.
//   slave  : trace sink; samples the record and drives trace_ready.
//   Signals: trace_valid / trace_ready handshake, trace_pc (32),
//            trace_wen (4), trace_wnum (5), trace_wdata (32).
interface wb_commit_unit_if;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [3:0]  trace_wen;
    logic [4:0]  trace_wnum;
    logic [31:0] trace_wdata;

    modport master (
        output trace_valid,
        output trace_pc,
        output trace_wen,
        output trace_wnum,
        output trace_wdata,
        input  trace_ready
    );

    modport slave (
        input  trace_valid,
        input  trace_pc,
        input  trace_wen,
        input  trace_wnum,
        input  trace_wdata,
        output trace_ready
    );
endinterface

// File: rtl/wb_commit_unit.sv
// wb_commit_unit
//   Write-back commit stage fed by the MEM/WB pipeline register. Aligns load
//   data, selects the register-file write value, owns architectural HI/LO and
//   pushes one trace record per committed instruction into a DEPTH-entry FIFO.
//   A full FIFO blocks commit and raises stall_req for the MEM/WB stage.
// Ports
//   clk, rst           : clock, asynchronous active-high reset
//   wb_valid .. MulDiv_result : MEM/WB slot contents (control and data)
//   rf_we/rf_waddr/rf_wdata   : register-file write port (combinational)
//   hi, lo             : architectural HI/LO registers
//   stall_req          : trace FIFO full, MEM/WB must hold
//   trace              : trace record channel (wb_commit_unit_if.master)
module wb_commit_unit #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic        wreg,
    input  logic [4:0]  regdst,
    input  logic [1:0]  result_sel,
    input  logic [3:0]  load_type,
    input  logic        whi,
    input  logic        wlo,
    input  logic        hi_i_sel,
    input  logic        lo_i_sel,
    input  logic        SC_result_sel,
    input  logic [31:0] ALU_result,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] rf_rdata0_fw,
    input  logic [31:0] rf_rdata1_fw,
    input  logic [31:0] PC_plus4,
    input  logic [63:0] MulDiv_result,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_req,
    wb_commit_unit_if.master trace
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q,  count_d;
    logic [31:0]   hi_q, lo_q;

    logic [31:0] pc_mem    [DEPTH];
    logic [3:0]  wen_mem   [DEPTH];
    logic [4:0]  wnum_mem  [DEPTH];
    logic [31:0] wdata_mem [DEPTH];

    logic        full;
    logic        commit;
    logic        push;
    logic        pop;
    logic        not_empty;
    logic [31:0] load_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Commit is suppressed while rst is high so rf_we stays low under reset.
    assign full      = (count_q == (PW+1)'(DEPTH));
    assign not_empty = (count_q != '0);
    assign commit    = wb_valid & ~full & ~rst;
    assign stall_req = full;
    assign push      = commit;
    assign pop       = not_empty & trace.trace_ready;

    assign rf_we    = commit & wreg & (regdst != 5'd0);
    assign rf_waddr = regdst;

    // Load alignment, little-endian byte lanes selected by ALU_result[1:0].
    always_comb begin
        ld_byte   = '0;
        ld_half   = '0;
        load_data = mem_rdata;
        case (ALU_result[1:0])
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = ALU_result[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (load_type)
            4'd1: load_data = {{24{ld_byte[7]}}, ld_byte};
            4'd2: load_data = {24'd0, ld_byte};
            4'd3: load_data = {{16{ld_half[15]}}, ld_half};
            4'd4: load_data = {16'd0, ld_half};
            4'd5: begin
                case (ALU_result[1:0])
                    2'd0:    load_data = {mem_rdata[7:0],  rf_rdata1_fw[23:0]};
                    2'd1:    load_data = {mem_rdata[15:0], rf_rdata1_fw[15:0]};
                    2'd2:    load_data = {mem_rdata[23:0], rf_rdata1_fw[7:0]};
                    default: load_data = mem_rdata;
                endcase
            end
            4'd6: begin
                case (ALU_result[1:0])
                    2'd0:    load_data = mem_rdata;
                    2'd1:    load_data = {rf_rdata1_fw[31:24], mem_rdata[31:8]};
                    2'd2:    load_data = {rf_rdata1_fw[31:16], mem_rdata[31:16]};
                    default: load_data = {rf_rdata1_fw[31:8],  mem_rdata[31:24]};
                endcase
            end
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        rf_wdata = ALU_result;
        case (result_sel)
            2'd0:    rf_wdata = ALU_result;
            2'd1:    rf_wdata = load_data;
            2'd2:    rf_wdata = PC_plus4 + 32'd4;
            default: rf_wdata = {31'd0, SC_result_sel};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (commit & whi) hi_q <= hi_i_sel ? MulDiv_result[63:32] : rf_rdata0_fw;
            if (commit & wlo) lo_q <= lo_i_sel ? MulDiv_result[31:0]  : rf_rdata0_fw;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

    // Full is evaluated before the edge, so a pop while full frees the slot
    // only for the following cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push & ~pop)      count_d = count_q + (PW+1)'(1);
        else if (pop & ~push) count_d = count_q - (PW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= PC_plus4 - 32'd4;
            wen_mem[wr_ptr_q]   <= rf_we ? 4'hF : 4'h0;
            wnum_mem[wr_ptr_q]  <= regdst;
            wdata_mem[wr_ptr_q] <= rf_wdata;
        end
    end

    // Record fields are forced to zero when empty, which also covers reset.
    assign trace.trace_valid = not_empty;
    assign trace.trace_pc    = not_empty ? pc_mem[rd_ptr_q]    : '0;
    assign trace.trace_wen   = not_empty ? wen_mem[rd_ptr_q]   : '0;
    assign trace.trace_wnum  = not_empty ? wnum_mem[rd_ptr_q]  : '0;
    assign trace.trace_wdata = not_empty ? wdata_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_wb_commit_unit.sv
module tb_wb_commit_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid, wreg, whi, wlo, hi_i_sel, lo_i_sel, SC_result_sel;
    logic [4:0]  regdst;
    logic [1:0]  result_sel;
    logic [3:0]  load_type;
    logic [31:0] ALU_result, mem_rdata, rf_rdata0_fw, rf_rdata1_fw, PC_plus4;
    logic [63:0] MulDiv_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, hi, lo;
    logic        stall_req;

    int n_checks = 0;
    int n_fail   = 0;

    wb_commit_unit_if tif ();

    wb_commit_unit #(.DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_valid      (wb_valid),
        .wreg          (wreg),
        .regdst        (regdst),
        .result_sel    (result_sel),
        .load_type     (load_type),
        .whi           (whi),
        .wlo           (wlo),
        .hi_i_sel      (hi_i_sel),
        .lo_i_sel      (lo_i_sel),
        .SC_result_sel (SC_result_sel),
        .ALU_result    (ALU_result),
        .mem_rdata     (mem_rdata),
        .rf_rdata0_fw  (rf_rdata0_fw),
        .rf_rdata1_fw  (rf_rdata1_fw),
        .PC_plus4      (PC_plus4),
        .MulDiv_result (MulDiv_result),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .hi            (hi),
        .lo            (lo),
        .stall_req     (stall_req),
        .trace         (tif.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load vectors: mem_rdata = 8899_AABB, rt = 1122_3344.
    logic [3:0]  ld_type [8] = '{4'd1, 4'd4, 4'd5, 4'd6, 4'd2, 4'd3, 4'd0, 4'd9};
    logic [1:0]  ld_addr [8] = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1};
    logic [31:0] ld_exp  [8] = '{32'hFFFF_FF99, 32'h0000_8899, 32'hAABB_3344, 32'h1188_99AA,
                                 32'h0000_0099, 32'hFFFF_AABB, 32'h8899_AABB, 32'h8899_AABB};

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        rst = 1'b1;
        wb_valid = 1'b1; wreg = 1'b1; regdst = 5'd5; result_sel = 2'd0; load_type = 4'd0;
        whi = 1'b0; wlo = 1'b0; hi_i_sel = 1'b0; lo_i_sel = 1'b0; SC_result_sel = 1'b0;
        ALU_result = 32'h0; mem_rdata = 32'h0; rf_rdata0_fw = 32'h0; rf_rdata1_fw = 32'h0;
        PC_plus4 = 32'h0; MulDiv_result = 64'h0;
        tif.trace_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_trace_valid", tif.trace_valid, 0);
        check("rst_stall", stall_req, 0);
        check("rst_rf_we", rf_we, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_trace_wdata", tif.trace_wdata, 0);
        wb_valid = 1'b0;
        rst = 1'b0;
        tick();

        // ALU commit
        wb_valid = 1'b1; wreg = 1'b1; regdst = 5'd5; result_sel = 2'd0;
        ALU_result = 32'h1234_5678; PC_plus4 = 32'hBFC0_0004;
        #1;
        check("alu_rf_we", rf_we, 1);
        check("alu_rf_waddr", rf_waddr, 5);
        check("alu_rf_wdata", rf_wdata, 32'h1234_5678);
        check("alu_no_bypass", tif.trace_valid, 0);
        tick();
        wb_valid = 1'b0;
        check("alu_trace_valid", tif.trace_valid, 1);
        check("alu_trace_pc", tif.trace_pc, 32'hBFC0_0000);
        check("alu_trace_wen", tif.trace_wen, 4'hF);
        check("alu_trace_wnum", tif.trace_wnum, 5);
        check("alu_trace_wdata", tif.trace_wdata, 32'h1234_5678);
        tick();
        check("alu_popped", tif.trace_valid, 0);

        // Load alignment (combinational)
        result_sel = 2'd1; mem_rdata = 32'h8899_AABB; rf_rdata1_fw = 32'h1122_3344;
        for (int i = 0; i < 8; i++) begin
            load_type = ld_type[i];
            ALU_result = {30'd0, ld_addr[i]};
            #1;
            check($sformatf("load_t%0d_a%0d", ld_type[i], ld_addr[i]), rf_wdata, ld_exp[i]);
        end

        // regdst = 0: committed but no register write
        wb_valid = 1'b1; regdst = 5'd0; result_sel = 2'd0;
        #1;
        check("r0_rf_we", rf_we, 0);
        tick();
        wb_valid = 1'b0;
        check("r0_trace_valid", tif.trace_valid, 1);
        check("r0_trace_wen", tif.trace_wen, 0);
        tick();

        // HI/LO
        wb_valid = 1'b1; wreg = 1'b0; whi = 1'b1; wlo = 1'b1; hi_i_sel = 1'b1; lo_i_sel = 1'b1;
        MulDiv_result = 64'hDEAD_BEEF_0000_0001;
        tick();
        check("hilo_hi", hi, 32'hDEAD_BEEF);
        check("hilo_lo", lo, 32'h1);
        wlo = 1'b0; hi_i_sel = 1'b0; rf_rdata0_fw = 32'd7;
        tick();
        check("hi_only_hi", hi, 7);
        check("hi_only_lo", lo, 1);
        wb_valid = 1'b0; rf_rdata0_fw = 32'd9;
        tick();
        check("hi_no_commit", hi, 7);
        whi = 1'b0;
        tick();

        // Backpressure: FIFO fills after 4 commits; instruction 5 is held.
        tif.trace_ready = 1'b0;
        wb_valid = 1'b1; wreg = 1'b1; regdst = 5'd3; result_sel = 2'd0; whi = 1'b1; hi_i_sel = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            v = (k < 5) ? 32'(k) : 32'd5;
            rf_rdata0_fw = v; ALU_result = v; PC_plus4 = 32'h100 + 4 * v;
            #1;
            check($sformatf("bp_stall_%0d", k), stall_req, (k >= 5) ? 1 : 0);
            check($sformatf("bp_rf_we_%0d", k), rf_we, (k >= 5) ? 0 : 1);
            tick();
        end
        check("bp_stall_full", stall_req, 1);
        check("bp_hi_4", hi, 4);
        check("bp_head_wdata", tif.trace_wdata, 1);
        check("bp_head_pc", tif.trace_pc, 32'h100);
        tif.trace_ready = 1'b1;
        tick();
        check("bp_pop_stall", stall_req, 0);
        check("bp_pop_hi", hi, 4);
        check("bp_pop_head", tif.trace_wdata, 2);
        tick();
        check("bp_held_commit_hi", hi, 5);
        check("bp_head3", tif.trace_wdata, 3);
        wb_valid = 1'b0; whi = 1'b0;
        tick();
        check("bp_head4", tif.trace_wdata, 4);
        tick();
        check("bp_head5", tif.trace_wdata, 5);
        check("bp_head5_pc", tif.trace_pc, 32'h110);
        tick();
        check("bp_drained", tif.trace_valid, 0);

        // Link wrap and SC flag
        wb_valid = 1'b1; regdst = 5'd31; result_sel = 2'd2; PC_plus4 = 32'hFFFF_FFFC;
        #1;
        check("link_wrap", rf_wdata, 0);
        tick();
        wb_valid = 1'b0;
        check("link_trace_pc", tif.trace_pc, 32'hFFFF_FFF8);
        check("link_trace_wdata", tif.trace_wdata, 0);
        result_sel = 2'd3; SC_result_sel = 1'b1;
        #1;
        check("sc_flag", rf_wdata, 1);
        tick();

        // Reset mid-burst with 3 records queued
        tif.trace_ready = 1'b0;
        wb_valid = 1'b1; result_sel = 2'd0; ALU_result = 32'hCAFE; whi = 1'b1; rf_rdata0_fw = 32'd55;
        repeat (3) tick();
        wb_valid = 1'b0; whi = 1'b0;
        check("mid_trace_valid", tif.trace_valid, 1);
        check("mid_stall", stall_req, 0);
        check("mid_hi", hi, 55);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_trace_valid", tif.trace_valid, 0);
        check("mid_rst_stall", stall_req, 0);
        check("mid_rst_hi", hi, 0);
        check("mid_rst_lo", lo, 0);
        check("mid_rst_trace_wdata", tif.trace_wdata, 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_empty", tif.trace_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
